simd_alu_issue_ctrl: RTL and testbench



---
 rtl/simd_alu_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_simd_alu_issue_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// simd_alu_issue_ctrl
//
// Command front end for the SIMD ALU. Accepted commands are registered onto the
// ALU inputs for exactly one cycle. Each command's tag travels alongside it
// through a tracking pipe that matches the ALU's fixed latency. When the tag
// leaves the pipe, the ALU result, the per-byte flags and the tag are written
// into an in-order response FIFO. A command is only accepted while the FIFO has
// room for every command still in flight, so an ALU result is never dropped.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_opcode, cmd_a/b      opcode and operand vectors
//   cmd_tag                  tag returned with the result
//   alu_opcode, alu_a/b      registered drive into the ALU
//   alu_out, alu_ovf/udf     ALU result and per-byte flags
//   rsp_valid / rsp_ready    response handshake
//   rsp_data, rsp_ovf/udf    head-of-FIFO result and flags
//   rsp_tag                  head-of-FIFO tag
//   busy                     command in flight or response pending
// -----------------------------------------------------------------------------
module simd_alu_issue_ctrl #(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int SIMD_OPC_WIDTH  = 6,
  parameter logic [SIMD_OPC_WIDTH-1:0] OPC_NOP = '0,
  parameter int ALU_LAT         = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int TAG_W           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [SIMD_OPC_WIDTH-1:0]    cmd_opcode,
  input  logic [SIMD_DATA_WIDTH-1:0]   cmd_a,
  input  logic [SIMD_DATA_WIDTH-1:0]   cmd_b,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic [SIMD_OPC_WIDTH-1:0]    alu_opcode,
  output logic [SIMD_DATA_WIDTH-1:0]   alu_a,
  output logic [SIMD_DATA_WIDTH-1:0]   alu_b,
  input  logic [SIMD_DATA_WIDTH-1:0]   alu_out,
  input  logic [SIMD_DATA_WIDTH/8-1:0] alu_ovf,
  input  logic [SIMD_DATA_WIDTH/8-1:0] alu_udf,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [SIMD_DATA_WIDTH-1:0]   rsp_data,
  output logic [SIMD_DATA_WIDTH/8-1:0] rsp_ovf,
  output logic [SIMD_DATA_WIDTH/8-1:0] rsp_udf,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         busy
);

  localparam int FLAG_W  = SIMD_DATA_WIDTH / 8;
  localparam int STAGES  = ALU_LAT + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W   = $clog2(STAGES + 1);
  localparam int SUM_W   = $clog2(FIFO_DEPTH + STAGES + 1) + 1;
  localparam int ENTRY_W = SIMD_DATA_WIDTH + 2 * FLAG_W + TAG_W;

  // ---------------------------------------------------------------------------
  // Credit: FIFO occupancy plus in-flight commands must stay below the depth.
  // Both terms are registered, so a pop only frees credit one cycle later.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] stage_valid_reg;
  logic [TAG_W-1:0]  stage_tag_reg [STAGES];
  logic [CNT_W-1:0]  fifo_count_reg;
  logic [INF_W-1:0]  inflight;
  logic [SUM_W-1:0]  occupancy;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + INF_W'(stage_valid_reg[i]);
    end
  end

  assign occupancy = SUM_W'(fifo_count_reg) + SUM_W'(inflight);
  assign cmd_ready = !rst && (occupancy < SUM_W'(FIFO_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = stage_valid_reg[STAGES-1];
  assign rsp_valid = (fifo_count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign fifo_full = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
  assign busy      = (inflight != '0) || (fifo_count_reg != '0);

  // ---------------------------------------------------------------------------
  // Issue register: an accepted command is shown to the ALU for one cycle,
  // every other cycle drives a NOP with zero operands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      alu_opcode <= OPC_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      alu_opcode <= cmd_opcode;
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking pipe: stage 0 holds the command currently on the ALU inputs; the
  // last stage lines up with the edge where its ALU result is valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_tag_reg[i] <= '0;
      end
    end else begin
      stage_valid_reg[0] <= accept;
      stage_tag_reg[0]   <= cmd_tag;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid_reg[i] <= stage_valid_reg[i-1];
        stage_tag_reg[i]   <= stage_tag_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO. Storage is a plain array (no reset) written at wr_ptr.
  // head_reg is a registered copy of the oldest entry and drives rsp_*.
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head_reg;
  logic [ENTRY_W-1:0] push_entry;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_inc;

  assign push_entry = {alu_out, alu_ovf, alu_udf, stage_tag_reg[STAGES-1]};
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  // The next head normally comes from the array at rd_ptr+1. When the FIFO
  // holds a single entry, the next head is the one being pushed on this very
  // edge and is not in the array yet, so it is taken straight from the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (pop) begin
      if (fifo_count_reg == CNT_W'(1)) begin
        if (push) begin
          head_reg <= push_entry;
        end
      end else begin
        head_reg <= fifo_mem[rd_ptr_inc];
      end
    end else if (push && (fifo_count_reg == '0)) begin
      head_reg <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      if (push && !pop) begin
        fifo_count_reg <= fifo_count_reg + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count_reg <= fifo_count_reg - CNT_W'(1);
      end
    end
  end

  assign rsp_data = head_reg[ENTRY_W-1 -: SIMD_DATA_WIDTH];
  assign rsp_ovf  = head_reg[TAG_W + 2*FLAG_W - 1 -: FLAG_W];
  assign rsp_udf  = head_reg[TAG_W + FLAG_W - 1 -: FLAG_W];
  assign rsp_tag  = head_reg[TAG_W-1:0];

  // The credit scheme makes a push into a full FIFO (without a matching pop)
  // unreachable; this catches any regression of that guarantee.
  push_while_full_check: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_simd_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for simd_alu_issue_ctrl. A small behavioural ALU stands in for
// simd_alu_top. A transaction-level model (queues of in-flight commands and
// pending responses) predicts every output each cycle; a few literal checks
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_simd_alu_issue_ctrl;

  localparam int W       = 256;
  localparam int FW      = W / 8;
  localparam int OPCW    = 6;
  localparam int ALU_LAT = 1;
  localparam int DEPTH   = 4;
  localparam int TW      = 4;
  localparam int RES_W   = W + 2 * FW;

  localparam logic [OPCW-1:0] OP_NOP   = 6'd0;
  localparam logic [OPCW-1:0] OP_ADD8  = 6'd1;
  localparam logic [OPCW-1:0] OP_ADD16 = 6'd2;
  localparam logic [OPCW-1:0] OP_ADD32 = 6'd3;
  localparam logic [OPCW-1:0] OP_ADD64 = 6'd4;
  localparam logic [OPCW-1:0] OP_SADD8 = 6'd5;
  localparam logic [OPCW-1:0] OP_SUB8  = 6'd6;
  localparam logic [OPCW-1:0] OP_SUB16 = 6'd7;
  localparam logic [OPCW-1:0] OP_SUB32 = 6'd8;
  localparam logic [OPCW-1:0] OP_SUB64 = 6'd9;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPCW-1:0] cmd_opcode;
  logic [W-1:0]    cmd_a;
  logic [W-1:0]    cmd_b;
  logic [TW-1:0]   cmd_tag;
  logic [OPCW-1:0] alu_opcode;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    alu_out;
  logic [FW-1:0]   alu_ovf;
  logic [FW-1:0]   alu_udf;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [FW-1:0]   rsp_ovf;
  logic [FW-1:0]   rsp_udf;
  logic [TW-1:0]   rsp_tag;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  simd_alu_issue_ctrl #(
    .SIMD_DATA_WIDTH(W),
    .SIMD_OPC_WIDTH (OPCW),
    .OPC_NOP        (OP_NOP),
    .ALU_LAT        (ALU_LAT),
    .FIFO_DEPTH     (DEPTH),
    .TAG_W          (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_tag   (cmd_tag),
    .alu_opcode(alu_opcode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_ovf   (alu_ovf),
    .alu_udf   (alu_udf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_udf   (rsp_udf),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-wise ALU arithmetic: bytes are added with a carry chain that restarts
  // at each lane boundary. S_ADD8 additionally reports signed byte overflow
  // (sum > 127) and underflow (sum < -128). Result = {data, ovf, udf}.
  function automatic logic [RES_W-1:0] alu_f(input logic [OPCW-1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0]  r;
    logic [FW-1:0] ov;
    logic [FW-1:0] uf;
    logic [7:0]    bb;
    logic [8:0]    s;
    logic          c;
    int            lb;
    int            sa;
    bit            sub;
    bit            sat;
    r = '0; ov = '0; uf = '0; c = 1'b0; lb = 1; sub = 0; sat = 0;
    case (op)
      OP_ADD8:  lb = 1;
      OP_ADD16: lb = 2;
      OP_ADD32: lb = 4;
      OP_ADD64: lb = 8;
      OP_SADD8: begin lb = 1; sat = 1; end
      OP_SUB8:  begin lb = 1; sub = 1; end
      OP_SUB16: begin lb = 2; sub = 1; end
      OP_SUB32: begin lb = 4; sub = 1; end
      OP_SUB64: begin lb = 8; sub = 1; end
      default:  return '0;
    endcase
    for (int j = 0; j < FW; j++) begin
      if (j % lb == 0) c = sub;
      bb = sub ? ~b[j*8 +: 8] : b[j*8 +: 8];
      s = {1'b0, a[j*8 +: 8]} + {1'b0, bb} + {8'd0, c};
      r[j*8 +: 8] = s[7:0];
      c = s[8];
      if (sat) begin
        sa = $signed(a[j*8 +: 8]) + $signed(b[j*8 +: 8]);
        ov[j] = (sa > 127);
        uf[j] = (sa < -128);
      end
    end
    return {r, ov, uf};
  endfunction

  // Stand-in ALU: registered result, ALU_LAT edges after its inputs.
  logic [RES_W-1:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_opcode, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_out, alu_ovf, alu_udf} = alu_pipe[ALU_LAT-1];

  // ---------------------------------------------------------------------------
  // Transaction model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [RES_W-1:0] res;
    logic [TW-1:0]    tag;
    int               due;
  } ent_t;

  ent_t            infl_q[$];
  ent_t            fifo_q[$];
  int              cyc = 0;
  logic [OPCW-1:0] m_op = OP_NOP;
  logic [W-1:0]    m_a = '0;
  logic [W-1:0]    m_b = '0;
  bit              m_zero = 1;

  function automatic bit m_ready();
    return !rst && ((fifo_q.size() + infl_q.size()) < DEPTH);
  endfunction

  always @(posedge clk) begin : model
    bit   acc;
    bit   pop;
    ent_t e;
    cyc++;
    if (rst) begin
      infl_q.delete();
      fifo_q.delete();
      m_op = OP_NOP; m_a = '0; m_b = '0; m_zero = 1;
    end else begin
      acc = cmd_valid && m_ready();
      pop = (fifo_q.size() != 0) && rsp_ready;
      if (pop) void'(fifo_q.pop_front());
      while (infl_q.size() != 0 && infl_q[0].due == cyc) begin
        fifo_q.push_back(infl_q.pop_front());
        m_zero = 0;
      end
      if (acc) begin
        e.res = alu_f(cmd_opcode, cmd_a, cmd_b);
        e.tag = cmd_tag;
        e.due = cyc + ALU_LAT + 1;
        infl_q.push_back(e);
        m_op = cmd_opcode; m_a = cmd_a; m_b = cmd_b;
      end else begin
        m_op = OP_NOP; m_a = '0; m_b = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmd_ready", W'(cmd_ready), W'(m_ready()));
      chk("rsp_valid", W'(rsp_valid), W'(fifo_q.size() != 0));
      chk("busy", W'(busy), W'((fifo_q.size() + infl_q.size()) != 0));
      chk("alu_opcode", W'(alu_opcode), W'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (fifo_q.size() != 0) begin
        chk("rsp_data", rsp_data, fifo_q[0].res[RES_W-1 -: W]);
        chk("rsp_ovf", W'(rsp_ovf), W'(fifo_q[0].res[2*FW-1 -: FW]));
        chk("rsp_udf", W'(rsp_udf), W'(fifo_q[0].res[FW-1:0]));
        chk("rsp_tag", W'(rsp_tag), W'(fifo_q[0].tag));
      end else if (m_zero) begin
        chk("rsp_data_rst", rsp_data, '0);
        chk("rsp_tag_rst", W'(rsp_tag), '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic send(input logic [OPCW-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] tag);
    bit done;
    int n;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    done = 0; n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("send_accept", W'(done), W'(1));
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrives", W'(rsp_valid), W'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [W-1:0]    va;
  logic [W-1:0]    vb;
  logic [W-1:0]    vexp;
  logic [OPCW-1:0] op;
  int              c0;
  int              c15;
  int              n_acc_dut;
  int              tag_ctr;
  bit              acc_now;
  bit              old_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = OP_NOP; cmd_a = '0; cmd_b = '0;
    cmd_tag = '0; rsp_ready = 1'b1;
    c0 = 0; c15 = 0;

    // Reset values
    idle(3);
    @(negedge clk);
    chk("rst_cmd_ready", W'(cmd_ready), W'(0));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_alu_opcode", W'(alu_opcode), W'(OP_NOP));
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", W'(cmd_ready), W'(1));
    idle(1);

    // Single ADD8: bytes i + (32-i) = 32
    for (int j = 0; j < FW; j++) begin
      va[j*8 +: 8] = 8'(j);
      vb[j*8 +: 8] = 8'(32 - j);
    end
    send(OP_ADD8, va, vb, 4'd5);
    @(negedge clk);
    chk("t1_opc_issue", W'(alu_opcode), W'(OP_ADD8));
    chk("t1_rsp_early", W'(rsp_valid), W'(0));
    @(negedge clk);
    chk("t1_opc_nop", W'(alu_opcode), W'(OP_NOP));
    chk("t1_rsp_early2", W'(rsp_valid), W'(0));
    @(negedge clk);
    vexp = {32{8'd32}};
    chk("t1_rsp_valid", W'(rsp_valid), W'(1));
    chk("t1_data", rsp_data, vexp);
    chk("t1_tag", W'(rsp_tag), W'(5));
    chk("t1_ovf", W'(rsp_ovf), '0);
    idle(3);

    // S_ADD8 overflow: 127 + 127
    va = {32{8'd127}};
    send(OP_SADD8, va, va, 4'd6);
    wait_rsp();
    vexp = {32{8'hFE}};
    chk("t2_data", rsp_data, vexp);
    chk("t2_ovf", W'(rsp_ovf), W'({32{1'b1}}));
    chk("t2_udf", W'(rsp_udf), '0);
    chk("t2_tag", W'(rsp_tag), W'(6));
    idle(3);

    // Back-to-back stream of 16 commands
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) begin
        op = OP_ADD16; va = rnd256(); vb = rnd256();
      end else if (i % 3 == 1) begin
        op = OP_SUB32; va = rnd256(); vb = rnd256();
      end else begin
        op = OP_SUB64; va = '0; vb = '1;
      end
      send(op, va, vb, 4'(i));
      if (i == 0) c0 = cyc;
      if (i == 15) c15 = cyc;
    end
    chk("t3_rate", W'(c15 - c0), W'(15));
    idle(6);
    send(OP_SUB64, '0, '1, 4'd9);
    wait_rsp();
    vexp = {4{64'd1}};
    chk("t3_sub64", rsp_data, vexp);
    idle(4);

    // Stall: rsp_ready low, continuous cmd_valid
    rsp_ready = 1'b0;
    tag_ctr = 0; n_acc_dut = 0;
    cmd_valid = 1'b1; cmd_opcode = OP_ADD32; cmd_a = rnd256(); cmd_b = rnd256();
    cmd_tag = 4'(tag_ctr);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc_now = cmd_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        n_acc_dut++; tag_ctr++; cmd_tag = 4'(tag_ctr); cmd_a = rnd256();
      end
    end
    chk("t4_accepts", W'(n_acc_dut), W'(DEPTH));
    chk("t4_ready_low", W'(cmd_ready), W'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_before_pop", W'(cmd_ready), W'(0));
    chk("t4_head_tag", W'(rsp_tag), W'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_ready_after_pop", W'(cmd_ready), W'(1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc_now = cmd_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        tag_ctr++; cmd_tag = 4'(tag_ctr); cmd_a = rnd256();
      end
    end
    cmd_valid = 1'b0;
    idle(8);

    // Push and pop on the same edge at the highest reachable occupancy
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD64, rnd256(), rnd256(), 4'(i));
    idle(1);
    rsp_ready = 1'b1;
    idle(8);

    // Reset with commands in flight and responses queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD8, rnd256(), rnd256(), 4'(10 + i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cmd_ready", W'(cmd_ready), W'(1));
    chk("t6_rsp_valid", W'(rsp_valid), W'(0));
    chk("t6_busy", W'(busy), W'(0));
    chk("t6_rsp_tag", W'(rsp_tag), '0);
    chk("t6_alu_opcode", W'(alu_opcode), W'(OP_NOP));
    rsp_ready = 1'b1;
    old_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_tag >= 4'd10) old_seen = 1;
    end
    chk("t6_no_old_tag", W'(old_seen), W'(0));
    idle(1);
    for (int j = 0; j < FW; j++) begin
      va[j*8 +: 8] = 8'(j);
      vb[j*8 +: 8] = 8'(32 - j);
    end
    send(OP_ADD8, va, vb, 4'd3);
    wait_rsp();
    vexp = {32{8'd32}};
    chk("t6_post_data", rsp_data, vexp);
    chk("t6_post_tag", W'(rsp_tag), W'(3));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
